// File: rtl/led_scan_pkg.sv
// Shared constants, types and the leading-zero helper for the LED digit scanner.
// Imported by the interface, the prescaler and the top.
package led_scan_pkg;

  localparam int NUM_DIGITS  = 8;
  localparam int NIBBLE_W    = 4;
  localparam int SEL_W       = 3;
  localparam int DIV_DEFAULT = 50000;
  localparam int VALUE_W     = NUM_DIGITS * NIBBLE_W;

  typedef logic [VALUE_W-1:0]  value_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;
  typedef logic [SEL_W-1:0]    sel_t;

  // High when digit `sel` and every more significant digit are zero.
  // Digit 0 is never reported, so a value of zero still shows one digit.
  function automatic logic lzHit(input value_t disp, input sel_t sel, input logic lzb);
    logic upperZero;
    upperZero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(sel) && disp[k*NIBBLE_W +: NIBBLE_W] != '0) upperZero = 1'b0;
    end
    return lzb && (sel != '0) && upperZero;
  endfunction

endpackage

// File: rtl/led_scan_if.sv
// Value/control inputs and digit outputs of the scanner, bundled as one port.
// master drives the value and controls; slave is the scanner itself.
interface led_scan_if;
  import led_scan_pkg::*;

  value_t  iValue;
  logic    iLoad;
  logic    iEn;
  logic    iLzb;
  nibble_t oData;
  sel_t    oSel;
  logic    oBlank;
  logic    oFrame;

  // iLoad is a single-cycle strobe with no back-pressure: every strobe is
  // accepted and a newer one simply replaces the pending value.
  modport master (
    output iValue, iLoad, iEn, iLzb,
    input  oData, oSel, oBlank, oFrame
  );

  modport slave (
    input  iValue, iLoad, iEn, iLzb,
    output oData, oSel, oBlank, oFrame
  );

endinterface

// File: rtl/led_scan_scan_tick.sv
// Digit-slot prescaler: counts 0..DIV-1 while enabled, holds while disabled,
// and pulses oTick in the last count of each slot.
module scan_tick #(
  parameter int DIV = 50000
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iEn,
  output logic oTick
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign oTick = iEn && (cnt == CNT_MAX);

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      cnt <= '0;
    end else if (iEn) begin
      cnt <= oTick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_scan.sv
// Eight-digit multiplexed display scanner: steps a digit index once per DIV
// clocks and only swaps the shown value at frame boundaries, so frames never tear.
module led_scan
  import led_scan_pkg::*;
#(
  parameter int DIV         = DIV_DEFAULT,
  parameter bit LZB_DEFAULT = 1'b0
) (
  input logic      iClk,
  input logic      iRst_n,
  led_scan_if.slave bus
);

  logic   enQ;
  logic   tick;
  logic   wrap;
  logic   commit;
  logic   lzb;
  logic   pend;
  logic   blankQ;
  logic   frameQ;
  value_t pending;
  value_t disp;
  value_t dispNext;
  sel_t   idx;
  sel_t   idxNext;

  scan_tick #(.DIV(DIV)) uScanTick (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .iEn   (enQ),
    .oTick (tick)
  );

  assign wrap     = tick && (idx == sel_t'(NUM_DIGITS - 1));
  assign commit   = wrap && pend;
  assign idxNext  = tick ? idx + sel_t'(1) : idx;
  assign dispNext = commit ? pending : disp;
  assign lzb      = bus.iLzb | LZB_DEFAULT;

  // A load in the commit cycle lands in pending after disp has taken the
  // old pending value, so pend stays set for the following frame.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      enQ     <= 1'b0;
      idx     <= '0;
      disp    <= '0;
      pending <= '0;
      pend    <= 1'b0;
      frameQ  <= 1'b0;
      blankQ  <= 1'b1;
    end else begin
      enQ  <= bus.iEn;
      idx  <= idxNext;
      disp <= dispNext;
      if (bus.iLoad) pending <= bus.iValue;
      pend   <= bus.iLoad | (pend & ~commit);
      frameQ <= wrap;
      blankQ <= ~bus.iEn | lzHit(dispNext, idxNext, lzb);
    end
  end

  assign bus.oSel   = idx;
  assign bus.oData  = disp[idx*NIBBLE_W +: NIBBLE_W];
  assign bus.oBlank = blankQ;
  assign bus.oFrame = frameQ;

endmodule

// File: tb/tb_led_scan.sv
// Bench for led_scan with DIV=4: vector table, hand-written corner sequences
// and a random run, all checked against a slot-position reference model.
module tb_led_scan;
  import led_scan_pkg::*;

  localparam int DIV   = 4;
  localparam bit LZBD  = 1'b0;
  localparam int FRAME = 8 * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  led_scan_if bus();

  led_scan #(.DIV(DIV), .LZB_DEFAULT(LZBD)) dut (
    .iClk  (clk),
    .iRst_n(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: position within the frame in enabled clocks.
  logic        mEnQ = 1'b0;
  int          mPos = 0;
  logic [31:0] mDisp = '0;
  logic [31:0] mPendV = '0;
  logic        mPend = 1'b0;
  logic        mBlank = 1'b1;
  logic        mFrame = 1'b0;

  logic        curEn = 1'b0;
  logic        curLzb = 1'b0;

  typedef struct {
    logic [31:0] value;
    logic        lzb;
    logic [7:0]  blankMask;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic lzRef(input logic [31:0] v, input int slot, input logic lz);
    if (!lz || slot == 0) return 1'b0;
    return (v >> (4 * slot)) == 32'd0;
  endfunction

  task automatic step(input logic r, input logic en, input logic ld, input logic lz,
                      input logic [31:0] v);
    logic wrapM;
    @(negedge clk);
    rst_n = r; bus.iEn = en; bus.iLoad = ld; bus.iLzb = lz; bus.iValue = v;
    @(posedge clk);
    if (!r) begin
      mEnQ = 1'b0; mPos = 0; mDisp = '0; mPendV = '0; mPend = 1'b0;
      mFrame = 1'b0; mBlank = 1'b1;
    end else begin
      wrapM = mEnQ && ((mPos + 1) % FRAME == 0);
      if (wrapM && mPend) begin
        mDisp = mPendV;
        mPend = 1'b0;
      end
      if (ld) begin
        mPendV = v;
        mPend  = 1'b1;
      end
      if (mEnQ) mPos = (mPos + 1) % FRAME;
      mFrame = wrapM;
      mEnQ   = en;
      mBlank = !en || lzRef(mDisp, mPos / DIV, lz | LZBD);
    end
    #1;
    check("model_sel", {29'd0, bus.oSel}, mPos / DIV);
    check("model_data", {28'd0, bus.oData}, (mDisp >> (4 * (mPos / DIV))) & 32'hF);
    check("model_blank", {31'd0, bus.oBlank}, {31'd0, mBlank});
    check("model_frame", {31'd0, bus.oFrame}, {31'd0, mFrame});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, curEn, 1'b0, curLzb, 32'd0);
  endtask

  task automatic runUntilPos(input int pos);
    int guard;
    guard = 0;
    while (mPos != pos && guard < 4 * FRAME) begin
      run(1);
      guard++;
    end
    check("pos_reached", (mPos == pos) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic runUntilFrame();
    int guard;
    guard = 0;
    do begin
      run(1);
      guard++;
    end while (bus.oFrame !== 1'b1 && guard < FRAME + 4);
    check("frame_seen", {31'd0, bus.oFrame}, 32'd1);
  endtask

  initial begin
    int frames;
    bus.iValue = '0; bus.iLoad = 1'b0; bus.iEn = 1'b0; bus.iLzb = 1'b0;

    vecs[0] = '{32'h8765_4321, 1'b0, 8'h00};
    vecs[1] = '{32'h0000_0A05, 1'b1, 8'hF8};
    vecs[2] = '{32'h0000_0000, 1'b1, 8'hFE};
    vecs[3] = '{32'h0000_0000, 1'b0, 8'h00};
    vecs[4] = '{32'h1000_0000, 1'b1, 8'h00};
    vecs[5] = '{32'h0000_F000, 1'b1, 8'hF0};
    vecs[6] = '{32'h8000_0000, 1'b1, 8'h00};

    // Reset state, with iEn already high during reset.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    check("rst_sel", {29'd0, bus.oSel}, 32'd0);
    check("rst_data", {28'd0, bus.oData}, 32'd0);
    check("rst_blank", {31'd0, bus.oBlank}, 32'd1);
    check("rst_frame", {31'd0, bus.oFrame}, 32'd0);

    // Scan cadence: first slot lasts DIV clocks after enable, one frame pulse per FRAME.
    curEn = 1'b1;
    run(1);
    check("en_unblank", {31'd0, bus.oBlank}, 32'd0);
    frames = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      run(1);
      check("cadence_sel", {29'd0, bus.oSel}, ((i + 1) / DIV) % 8);
      if (bus.oFrame === 1'b1) frames++;
    end
    check("frame_count", frames, 32'd2);

    // Vector table: value shows only from the next frame, with its blank pattern.
    for (int v = 0; v < 7; v++) begin
      curLzb = vecs[v].lzb;
      step(1'b1, curEn, 1'b1, curLzb, vecs[v].value);
      runUntilFrame();
      for (int k = 0; k < 8; k++) exp_q.push_back((vecs[v].value >> (4 * k)) & 32'hF);
      for (int k = 0; k < 8; k++) begin
        check("vec_sel", {29'd0, bus.oSel}, k);
        check("vec_data", {28'd0, bus.oData}, exp_q.pop_front());
        check("vec_blank", {31'd0, bus.oBlank}, {31'd0, vecs[v].blankMask[k]});
        if (k < 7) run(DIV);
      end
    end

    // Mid-frame load is not visible before the wrap.
    curLzb = 1'b0;
    runUntilPos(2 * DIV);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h8765_4321);
    run(DIV);
    check("no_tear", {28'd0, bus.oData}, 32'd0);

    // Load A exactly in the wrap cycle while B is pending.
    runUntilFrame();
    runUntilPos(2 * DIV);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'hBBBB_BBB2);
    runUntilPos(FRAME - 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'hAAAA_AAA7);
    check("wrap_frame", {31'd0, bus.oFrame}, 32'd1);
    check("wrap_takes_b", {28'd0, bus.oData}, 32'h2);
    runUntilFrame();
    check("next_takes_a", {28'd0, bus.oData}, 32'h7);

    // Enable drop in slot 5 freezes and blanks, then the slot finishes.
    runUntilPos(5 * DIV + 1);
    curEn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      run(1);
      check("hold_blank", {31'd0, bus.oBlank}, 32'd1);
      check("hold_sel", {29'd0, bus.oSel}, 32'd5);
    end
    curEn = 1'b1;
    run(1);
    check("resume_sel0", {29'd0, bus.oSel}, 32'd5);
    run(1);
    check("resume_sel1", {29'd0, bus.oSel}, 32'd5);
    run(1);
    check("resume_sel2", {29'd0, bus.oSel}, 32'd6);

    // Reset mid-frame with a pending value discards it.
    runUntilPos(2 * DIV);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h1234_5678);
    run(3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    check("mrst_sel", {29'd0, bus.oSel}, 32'd0);
    check("mrst_data", {28'd0, bus.oData}, 32'd0);
    check("mrst_blank", {31'd0, bus.oBlank}, 32'd1);
    check("mrst_frame", {31'd0, bus.oFrame}, 32'd0);
    runUntilFrame();
    run(DIV * 7);
    check("mrst_discard", {28'd0, bus.oData}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic        r;
      logic        ld;
      logic [31:0] v;
      r     = ($urandom_range(0, 199) != 0);
      curEn = ($urandom_range(0, 19) != 0);
      ld    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) curLzb = ~curLzb;
      v = $urandom;
      for (int k = 0; k < 8; k++) if ($urandom_range(0, 1) == 0) v[4*k +: 4] = 4'h0;
      step(r, curEn, ld, curLzb, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_scan.md
LED_SCAN -- requirements
Module: led_scan

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clocks per digit slot; legal range is DIV >= 2.
REQ-002 SHALL have parameter LZB_DEFAULT, default 0, meaning the leading-zero blanking state used when iLzb is tied low.
REQ-003 One clock; reset is synchronous and active-low; ports iClk and iRst_n.
REQ-004 iClk  input  1  system clock; all state on rising edge.
REQ-005 iRst_n  input  1  synchronous active-low reset.
REQ-006 iValue  input  32  eight hex digits; digit k = iValue[4k+3:4k].
REQ-007 iLoad  input  1  single-cycle strobe; capture iValue as pending display value.
REQ-008 iEn  input  1  scan enable; low freezes scan and blanks display.
REQ-009 iLzb  input  1  leading-zero blanking enable (ORed with LZB_DEFAULT).
REQ-010 oData  output  4  nibble for the selected digit; feeds the downstream digit-select/7-seg stage iData.
REQ-011 oSel  output  3  binary digit index 0..7; feeds the downstream stage iSel.
REQ-012 oBlank  output  1  high = downstream must suppress the current digit.
REQ-013 oFrame  output  1  one-cycle pulse per completed 8-digit frame.

Function
REQ-014 Prescaler cnt SHALL count 0..DIV-1 while en_q=1, hold while en_q=0, and assert tick in the cycle cnt==DIV-1 and en_q=1, wrapping to 0.
REQ-015 Digit index idx SHALL increment on tick, wrap 7->0, and hold otherwise; oSel = idx.
REQ-016 oData SHALL equal disp[4*idx+3:4*idx]; oData/oSel depend only on registers, with no combinational input-to-output path.
REQ-017 iLoad=1 SHALL write iValue into pending and set pend=1 on that edge; back-to-back loads overwrite pending (last wins).
REQ-018 On a tick with idx==7 (frame wrap) and pend=1, disp SHALL load pending and pend SHALL clear; disp never changes mid-frame (no tearing).
REQ-019 When iLoad and a frame-wrap commit occur in the same cycle, disp SHALL take the pre-edge pending, pending SHALL take the new iValue, and pend SHALL remain 1.
REQ-020 en_q SHALL be iEn registered; one cycle after iEn falls, scan freezes and oBlank=1; on re-enable, scan resumes from the held cnt/idx.
REQ-021 Leading-zero blanking SHALL be active when lzb = iLzb | LZB_DEFAULT; when lzb=1 and idx>0, lz_hit=1 iff disp nibbles idx..7 are all zero; digit 0 is never blanked by LZB.
REQ-022 oBlank SHALL be registered: oBlank <= ~iEn | lz_hit(next idx, next disp), so it aligns with oSel/oData of the same cycle.
REQ-023 oFrame SHALL be registered and high for exactly the one cycle in which idx has just wrapped 7->0.
REQ-024 Frame period SHALL be 8*DIV clocks with iEn held high.

Reset
REQ-025 iRst_n low at an edge SHALL set cnt=0, idx=0, disp=0, pending=0, pend=0, en_q=0, oFrame=0, and oBlank=1; hence oSel=0 and oData=0.
REQ-026 Reset SHALL take priority over iLoad/tick in the same cycle; reset mid-frame discards any pending value.
REQ-027 The first tick after reset SHALL occur DIV clocks after en_q first becomes 1.

Structure
REQ-028 A shared package SHALL hold NUM_DIGITS=8, NIBBLE_W=4, SEL_W=3, and DIV_DEFAULT=50000.
REQ-029 Prescaler SHALL be a sub-module scan_tick (parameter DIV, inputs iClk/iRst_n/iEn, output oTick), with cnt width $clog2(DIV).
REQ-030 led_scan SHALL contain pending/disp registers, idx counter, LZB compare, and output registers; expected size is 120-250 lines.

Verification (DIV=4)
REQ-031 Reset then iEn=1 -> oBlank=1 until en_q=1, oSel steps 0,1..7,0 every 4 clocks, and oFrame pulses once per 32 clocks.
REQ-032 iLoad with iValue=32'h8765_4321 mid-frame -> oData stays 0 until the wrap, then reads 1,2,..,8 for oSel 0..7 in the next frame.
REQ-033 iLzb=1, disp=32'h0000_0A05 -> oBlank=0 for oSel 0..2 and oBlank=1 for oSel 3..7; disp=0 -> only oSel=0 unblanked.
REQ-034 iLoad with value A in the wrap cycle while pending=B -> disp=B this frame, then disp=A after the next wrap.
REQ-035 iEn dropped at oSel=5, cnt=2 for 10 clocks -> oBlank=1 and oSel/cnt hold; after re-enable, oSel=5 completes its remaining 2 clocks.
REQ-036 iRst_n low for 1 cycle mid-frame with pend=1 -> all outputs at reset values, and pending is not committed at the next wrap.
